frame_checker: RTL
==================

FRAME_CHECKER -- requirements
Module: frame_checker

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 Parameter MAX_LEN, default 16: largest legal payload length in bytes, range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 shift_enable  input  1  byte strobe; data_in is consumed only on cycles where it is high.
REQ-006 data_in  input  8  byte stream from the delay-line stage output.
REQ-007 payload_data  output  8  last accepted payload byte.
REQ-008 payload_valid  output  1  one-cycle pulse when payload_data is updated.
REQ-009 frame_ok  output  1  one-cycle pulse when a frame passes its checksum.
REQ-010 frame_err  output  1  one-cycle pulse on a length or checksum violation.
REQ-011 busy  output  1  high while the state is not HUNT.
REQ-012 ok_count  output  8  count of good frames, saturating.
REQ-013 err_count  output  8  count of bad frames, saturating.

Function
REQ-014 Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK; CHK equals the 8-bit modulo-256 sum of the payload bytes.
REQ-015 FSM states: HUNT, LEN, PAYLOAD, CHECK; transitions occur only on cycles with shift_enable=1.
REQ-016 HUNT: if data_in==SYNC_BYTE, go to LEN; otherwise stay in HUNT with no output pulse.
REQ-017 LEN: if data_in==0 or data_in>MAX_LEN, pulse frame_err, increment err_count, and go to HUNT.
REQ-018 LEN: otherwise load the remaining-byte counter with data_in, clear the sum, and go to PAYLOAD.
REQ-019 PAYLOAD: on each accepted byte:
  - register it to payload_data and pulse payload_valid;
  - add it to the sum, wrapping at 8 bits;
  - decrement the counter.
  After the byte that takes the counter to 0, go to CHECK.
REQ-020 In PAYLOAD, a byte equal to SYNC_BYTE is payload data and does not resynchronise the FSM.
REQ-021 CHECK: if data_in equals the sum, pulse frame_ok and increment ok_count.
REQ-022 CHECK: otherwise pulse frame_err and increment err_count; in both cases go to HUNT.
REQ-023 All outputs are registered; each pulse is asserted in the cycle after the rising edge that consumed the triggering byte, for exactly one cycle.
REQ-024 When shift_enable=0, state, counter, sum and payload_data hold, and all pulses are 0.
REQ-025 ok_count and err_count saturate at 255 and do not wrap.
REQ-026 frame_ok and frame_err are never asserted in the same cycle.
REQ-027 A SYNC_BYTE seen in CHECK is consumed as the checksum and is not treated as a new frame start.

Reset
REQ-028 While rst=1 at a clock edge:
  - state goes to HUNT;
  - counter, sum, payload_data, ok_count and err_count go to 0;
  - payload_valid, frame_ok, frame_err and busy go to 0.
REQ-029 Reset asserted mid-frame abandons the frame with no frame_err pulse and no counter change.
REQ-030 rst takes priority over shift_enable.

Structure
REQ-031 A shared package holds the FSM state enumeration (2-bit encoding) and the default SYNC_BYTE and MAX_LEN constants.
REQ-032 One sub-module, frame_checker_sat8, implements the 8-bit saturating counter; it is instantiated twice (ok_count, err_count).
REQ-033 The datapath is a single always block for the FSM, counter and sum; no memories are used.

Verification
REQ-034 Good frame: stream A5,03,10,20,30,60 with shift_enable=1 -> payload_valid three times (10,20,30); frame_ok one cycle after the 60 is consumed; ok_count=1.
REQ-035 Bad checksum: stream A5,02,FF,02,00 -> frame_err pulse; err_count=1; payload sum wraps to 01 and does not match 00.
REQ-036 Illegal length: stream A5,00, then A5,11 (MAX_LEN=16) -> two frame_err pulses and no payload_valid; busy returns low after each.
REQ-037 Gapped strobe and embedded sync: stream A5,02,A5,01,A6 with shift_enable low for 3 cycles between each byte -> identical pulses as the ungapped case; frame_ok asserted; no pulses while the strobe is low.
REQ-038 Reset mid-frame: stream A5,04,11, then rst for 1 cycle, then A5,01,07,07 -> no frame_err; one frame_ok; ok_count=1.
REQ-039 Saturation: 300 consecutive good frames -> ok_count reads 255 and err_count reads 0.

Source files
------------

// File: rtl/frame_checker_pkg.sv
// Shared definitions for the frame checker: FSM state encoding and
// default framing constants.
package frame_checker_pkg;

    // Two-bit FSM encoding; the numeric values are visible on state_dbg.
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         DEFAULT_MAX_LEN   = 16;

endpackage

// File: rtl/frame_checker_sat8.sv
// Eight-bit up-counter that sticks at 255 instead of wrapping.
module frame_checker_sat8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] count
);

    // Count increment requests, holding at the top value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/frame_checker.sv
// Frame checker: hunts for SYNC_BYTE, reads a length byte, forwards the
// payload bytes and compares the trailing checksum with the 8-bit sum of
// the payload. Good and bad frames are tallied in saturating counters.
//
// Handshake: shift_enable is a valid-only strobe with no ready; every byte
// presented while shift_enable is high is consumed on that rising edge.
// Nothing advances and no pulse is produced while it is low.
module frame_checker
    import frame_checker_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN   = DEFAULT_MAX_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_enable,
    input  logic [7:0] data_in,
    output logic [7:0] payload_data,
    output logic       payload_valid,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] ok_count,
    output logic [7:0] err_count,
    output logic [1:0] state_dbg
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] pdata_d;
    logic       pvalid_d, ok_d, err_d;

    // Next-state, counter, checksum and pulse decode for one strobed byte.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        pdata_d  = payload_data;
        pvalid_d = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        if (shift_enable) begin
            case (state_q)
                ST_HUNT: begin
                    if (data_in == SYNC_BYTE) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if ((data_in == 8'd0) || (data_in > MAX_LEN_B)) begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end else begin
                        cnt_d   = data_in;
                        sum_d   = 8'd0;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    // A sync value here is ordinary payload data.
                    pdata_d  = data_in;
                    pvalid_d = 1'b1;
                    sum_d    = sum_q + data_in;
                    cnt_d    = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Whatever arrives here is the checksum, sync value included.
                    if (data_in == sum_q) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_HUNT;
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // Register FSM state, datapath and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            cnt_q         <= 8'd0;
            sum_q         <= 8'd0;
            payload_data  <= 8'd0;
            payload_valid <= 1'b0;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            payload_data  <= pdata_d;
            payload_valid <= pvalid_d;
            frame_ok      <= ok_d;
            frame_err     <= err_d;
            busy          <= (state_d != ST_HUNT);
        end
    end

    assign state_dbg = state_q;

    frame_checker_sat8 u_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ok_d),
        .count (ok_count)
    );

    frame_checker_sat8 u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_d),
        .count (err_count)
    );

endmodule
